// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared state encodings and boundary payload widths
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Payload widths per stage boundary (concatenation of that boundary's fields)
  localparam int W_EX_MM1  = 32 + 32 + 8;
  localparam int W_MM1_MM2 = 32 + 2 + 2 + 1 + 5 + 8 + 3 + 1 + 32;

  function automatic logic [1:0] state_count(input skid_state_e s);
    case (s)
      ST_ONE:  state_count = 2'd1;
      ST_TWO:  state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - payload register with load enable, sync clear, reset to zero
module pipe_data_reg #(
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready inter-stage register, optional two-entry skid
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W       = 72,
  parameter int SKID         = 1,
  parameter int CLR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              clr;
  logic [DATA_W-1:0] main_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign clr      = flush & (CLR_ON_FLUSH != 0);

  pipe_data_reg #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e       state_q;
      skid_state_e       state_d;
      logic              skid_load;
      logic              main_from_skid;
      logic [DATA_W-1:0] skid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= ST_EMPTY;
        end else begin
          state_q <= state_d;
        end
      end

      always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              main_load = 1'b1;
              state_d   = ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_load = 1'b1;
            end else if (in_fire) begin
              skid_load = 1'b1;
              state_d   = ST_TWO;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              state_d        = ST_ONE;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        // Flush wins: incoming beat dropped, held payload either zeroed or frozen
        if (flush) begin
          state_d   = ST_EMPTY;
          main_load = 1'b0;
          skid_load = 1'b0;
        end
      end

      pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
      );

      assign main_d    = main_from_skid ? skid_q : in_data;
      // Ready comes from the state register only, so out_ready never reaches it
      assign in_ready  = (state_q != ST_TWO);
      assign out_valid = (state_q != ST_EMPTY);
      assign count     = state_count(state_q);
    end else begin : g_single
      logic valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end

      assign main_load = in_fire & ~flush;
      assign main_d    = in_data;
      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign count     = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for skid (clear/hold) and single-register modes
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       c_in_ready, c_out_valid;
  logic [7:0] c_out_data;
  logic [1:0] c_count;
  logic       h_in_ready, h_out_valid;
  logic [7:0] h_out_data;
  logic [1:0] h_count;
  logic       z_in_ready, z_out_valid;
  logic [7:0] z_out_data;
  logic [1:0] z_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] last_c, last_h, last_z;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(8), .SKID(1), .CLR_ON_FLUSH(1)) u_clr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID(1), .CLR_ON_FLUSH(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
    .count(h_count)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID(0), .CLR_ON_FLUSH(1)) u_single (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
    .count(z_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic ordy);
    logic [7:0] e1, e0;
    e1 = (q1.size() > 0) ? q1[0] : last_c;
    chk("clr_out_valid", c_out_valid, q1.size() > 0);
    chk("clr_count", c_count, q1.size());
    chk("clr_in_ready", c_in_ready, q1.size() < 2);
    chk("clr_out_data", c_out_data, e1);
    e1 = (q1.size() > 0) ? q1[0] : last_h;
    chk("hold_out_valid", h_out_valid, q1.size() > 0);
    chk("hold_count", h_count, q1.size());
    chk("hold_in_ready", h_in_ready, q1.size() < 2);
    chk("hold_out_data", h_out_data, e1);
    e0 = (q0.size() > 0) ? q0[0] : last_z;
    chk("single_out_valid", z_out_valid, q0.size() > 0);
    chk("single_count", z_count, q0.size());
    chk("single_in_ready", z_in_ready, (q0.size() == 0) || ordy);
    chk("single_out_data", z_out_data, e0);
    // Flip out_ready mid-cycle: skid ready must not move, single ready must follow
    out_ready = ~ordy;
    #1;
    chk("clr_in_ready_indep", c_in_ready, q1.size() < 2);
    chk("hold_in_ready_indep", h_in_ready, q1.size() < 2);
    chk("single_in_ready_comb", z_in_ready, (q0.size() == 0) || !ordy);
    out_ready = ordy;
    #1;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    logic f1_in, f1_out, f0_in, f0_out;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(ordy);
    f1_in  = v && (q1.size() < 2);
    f1_out = (q1.size() > 0) && ordy;
    f0_in  = v && ((q0.size() == 0) || ordy);
    f0_out = (q0.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      last_c = 8'h00;
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in) q1.push_back(d);
    end
    if (q1.size() > 0) begin
      last_c = q1[0];
      last_h = q1[0];
    end
    if (fl) begin
      q0.delete();
      last_z = 8'h00;
    end else begin
      if (f0_out) void'(q0.pop_front());
      if (f0_in) q0.push_back(d);
    end
    if (q0.size() > 0) last_z = q0[0];
    @(negedge clk);
  endtask

  task automatic do_reset(input logic fl);
    rst_n     = 1'b0;
    flush     = fl;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    @(posedge clk);
    q1.delete();
    q0.delete();
    last_c = 8'h00;
    last_h = 8'h00;
    last_z = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Streaming with out_ready held high
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: third beat must wait upstream
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b1, 1'b0);
    cycle(1'b1, 8'hA3, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while full, with a beat arriving
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0);
    cycle(1'b1, 8'hB3, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_hold_keeps_b1", h_out_data, 8'hB1);
    chk("flush_clr_zero", c_out_data, 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Single-register replacement in one edge
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset with two beats held, then reset coinciding with flush
    cycle(1'b1, 8'hD1, 1'b0, 1'b0);
    cycle(1'b1, 8'hD2, 1'b0, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0);
    cycle(1'b1, 8'hE8, 1'b0, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register carrying an opaque payload between two adjacent CPU pipeline stages (e.g. MM1→MM2, EX→MM1). It replaces the fixed-field, wen-controlled stage registers with a valid/ready handshake. An optional two-entry skid mode breaks the combinational ready path, and a flush invalidates all held beats. One instance sits on each stage boundary; the payload is the concatenation of that boundary's fields.

## Interface
Parameters:
- DATA_W, 72, payload width in bits (≥1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLR_ON_FLUSH, 1, 1 = payload registers are zeroed on flush; 0 = payload is held and only validity is cleared.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kill all held and incoming beats this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head beat.
- count  out  2  occupancy, 0..2; 0..1 when SKID=0.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- SKID=1 uses a main register (drives out_*) and a skid register, with state ST_EMPTY, ST_ONE or ST_TWO.
  - in_ready = (state != ST_TWO), decoded from the state register only. There is no path from out_ready.
  - ST_EMPTY: in_fire → main←in_data, ST_ONE.
  - ST_ONE: in_fire & out_fire → main←in_data, ST_ONE. in_fire only → skid←in_data, ST_TWO. out_fire only → ST_EMPTY.
  - ST_TWO: out_fire → main←skid, ST_ONE. in_fire is impossible in this state.
  - out_valid = (state != ST_EMPTY). count = 0, 1 or 2 by state.
- SKID=0 uses the main register only.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main and sets valid. out_fire without in_fire clears valid.
- Flush has highest priority, in both modes:
  - Next state is ST_EMPTY (valid = 0) and count = 0.
  - A beat with in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream; downstream is flushed by the same signal.
  - If CLR_ON_FLUSH=1, main and skid are loaded with 0.
- Payload is never modified; bit order is preserved end to end.
- Reset sets all outputs: out_valid=0, out_data=0, count=0. in_ready=1 in SKID=1 (state ST_EMPTY), and 1 in SKID=0.

## Timing
- Latency: in_fire at edge N gives out_valid=1 and out_data=in_data in the cycle after edge N (1-cycle latency).
- Throughput is one beat per cycle when out_ready is held high, in both modes.
- SKID=1, when out_ready falls:
  - At most one extra beat is absorbed, into skid.
  - in_ready falls in the cycle after the second beat is accepted.
  - in_ready rises the cycle after the next out_fire.
- Upstream must hold in_valid/in_data stable until in_fire. This block does the same for out_valid/out_data until out_fire or flush.
- Simultaneous flush and rst_n=0: reset wins. The result is identical in either case.
- Reset mid-transfer: held beats are lost. No beat is emitted in the cycle after reset.

## Structure
- Shared defs package holds:
  - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - the per-boundary payload-width constants (e.g. W_MM1_MM2 = 32+2+2+1+5+8+3+1+32 = 86).
- One natural sub-module: pipe_data_reg, a DATA_W register with load-enable, sync clear and a reset value of 0. It is instantiated for main, and for skid only when SKID=1.
- SKID=0 and SKID=1 are selected by generate. The interface is identical in both modes.

## Test plan
- Streaming: SKID=1, DATA_W=8, out_ready=1, beats 0x01..0x10 on consecutive cycles → 16 outputs in order, each 1 cycle after its input; in_ready stays 1; count ≤1.
- Backpressure: out_ready=0 while sending 0xA1, 0xA2, 0xA3 →
  - 0xA1 and 0xA2 accepted; count=2; in_ready=0 the following cycle; 0xA3 held upstream.
  - After out_ready=1, the order is A1, A2, A3 with no loss or duplication.
- Flush in ST_TWO: flush with in_valid=1 →
  - next cycle out_valid=0, count=0, in_ready=1;
  - out_data=0 with CLR_ON_FLUSH=1, and the old main value with CLR_ON_FLUSH=0;
  - the incoming beat never appears.
- SKID=0: out_ready=0 with a beat held → in_ready=0 in the same cycle. Raising out_ready with in_valid=1 gives in_ready=1 combinationally, and the new beat replaces the old one in one edge.
- Reset mid-operation: rst_n=0 for one cycle with count=2 → out_valid=0, out_data=0, count=0 the next cycle; streaming then resumes normally.
- Random: random in_valid/out_ready/flush (5%) over 10k cycles against a reference queue model. Check ordering, no loss except on flush, count consistency, and that in_ready never depends on out_ready when SKID=1.
